// File: rtl/regfile_dump.sv
// Debug read-out engine: walks x0..x(NREGS-1) through a combinational read port and streams them out.
// Optional trailing XOR checksum beat is compiled in with REGFILE_DUMP_CHECKSUM_EN.
module regfile_dump #(
    parameter int N     = 32,
    parameter int NREGS = 32,
    parameter int A     = $clog2(NREGS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [A-1:0] rf_addr,
    input  logic [N-1:0] rf_data,
    output logic         halt_req,
    output logic         busy,
    output logic         done,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [A-1:0] out_idx,
    output logic         out_last
);

    localparam logic [A-1:0] LAST_IDX = A'(NREGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_SEND,
`ifdef REGFILE_DUMP_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [A-1:0]   idx_reg;
    logic [N-1:0]   data_reg;
    logic [A-1:0]   oidx_reg;
    logic           at_last;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [N-1:0]   acc_reg;
`endif

    assign at_last  = (idx_reg == LAST_IDX);
    assign out_data = data_reg;
    assign out_idx  = oidx_reg;
    assign halt_req = busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rf_addr    = '0;
        busy       = 1'b0;
        done       = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_READ;
                end
            end
            S_READ: begin
                rf_addr    = idx_reg;
                busy       = 1'b1;
                state_next = S_SEND;
            end
            S_SEND: begin
                rf_addr   = idx_reg;
                busy      = 1'b1;
                out_valid = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                out_last  = 1'b0;
`else
                out_last  = at_last;
`endif
                if (out_ready) begin
                    if (at_last) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        state_next = S_CSUM;
`else
                        state_next = S_DONE;
`endif
                    end else begin
                        state_next = S_READ;
                    end
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            S_CSUM: begin
                rf_addr   = idx_reg;
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = 1'b1;
                if (out_ready) begin
                    state_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Beat payload only changes in READ (or when the checksum beat is loaded),
    // so it is naturally held while the sink stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg  <= '0;
            data_reg <= '0;
            oidx_reg <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc_reg  <= '0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        idx_reg <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        acc_reg <= '0;
`endif
                    end
                end
                S_READ: begin
                    data_reg <= rf_data;
                    oidx_reg <= idx_reg;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    acc_reg  <= acc_reg ^ rf_data;
`endif
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (!at_last) begin
                            idx_reg <= idx_reg + A'(1);
                        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        else begin
                            data_reg <= acc_reg;
                            oidx_reg <= '0;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump; follows REGFILE_DUMP_CHECKSUM_EN to expect the checksum beat.
// A behavioural model builds the expected beat list from the register contents.
module tb_regfile_dump;

    localparam int N     = 32;
    localparam int NREGS = 32;
    localparam int A     = 5;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif
    localparam int NBEATS = NREGS + (CSUM ? 1 : 0);
    localparam int T_DONE = 2 * NREGS + 1 + (CSUM ? 1 : 0);

    logic         clk;
    logic         rst;
    logic         start;
    logic [A-1:0] rf_addr;
    logic [N-1:0] rf_data;
    logic         halt_req;
    logic         busy;
    logic         done;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [A-1:0] out_idx;
    logic         out_last;

    logic [N-1:0] regs [NREGS];
    assign rf_data = regs[rf_addr];

    regfile_dump #(.N(N), .NREGS(NREGS), .A(A)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rf_addr(rf_addr), .rf_data(rf_data),
        .halt_req(halt_req), .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Captured stream of one dump
    logic [N-1:0] cap_data [$];
    logic [A-1:0] cap_idx  [$];
    logic         cap_last [$];
    int           cap_cyc  [$];
    int ndone, done_cyc, halt_first, halt_last, hb_bad, hold_bad, post_busy, nstall, stall0_bad;

    // Expected stream
    logic [N-1:0] exp_data [$];
    logic [A-1:0] exp_idx  [$];
    logic         exp_last [$];

    task automatic load_spec();
        regs[0] = '0;
        for (int k = 1; k < NREGS; k++) regs[k] = 32'h100 + N'(k);
    endtask

    task automatic load_random();
        for (int k = 0; k < NREGS; k++) regs[k] = $urandom;
    endtask

    task automatic build_model();
        logic [N-1:0] x;
        x = '0;
        exp_data.delete(); exp_idx.delete(); exp_last.delete();
        for (int k = 0; k < NREGS; k++) begin
            exp_data.push_back(regs[k]);
            exp_idx.push_back(A'(k));
            exp_last.push_back(!CSUM && (k == NREGS - 1));
            x ^= regs[k];
        end
        if (CSUM) begin
            exp_data.push_back(x);
            exp_idx.push_back('0);
            exp_last.push_back(1'b1);
        end
    endtask

    // Runs one dump; t counts cycles after the edge that sampled start (t=1 is READ of beat 0).
    task automatic run_dump(input int stall_at, input int stall_len, input bit rand_ready,
                            input int poke_at, input int abort_at);
        int beat, stall_left;
        bit prev_hold;
        logic [N-1:0] pd;
        logic [A-1:0] pi;
        logic pl;
        cap_data.delete(); cap_idx.delete(); cap_last.delete(); cap_cyc.delete();
        ndone = 0; done_cyc = -1; halt_first = -1; halt_last = -1; hb_bad = 0;
        hold_bad = 0; post_busy = 0; nstall = 0; stall0_bad = 0;
        beat = 0; stall_left = stall_len; prev_hold = 1'b0; pd = '0; pi = '0; pl = 1'b0;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 1; t <= 600; t++) begin
            if (halt_req !== busy) hb_bad++;
            if (busy === 1'b1) begin
                if (halt_first < 0) halt_first = t;
                halt_last = t;
            end
            if (prev_hold && (out_valid !== 1'b1 || out_data !== pd || out_idx !== pi || out_last !== pl))
                hold_bad++;
            if (done === 1'b1) begin
                ndone++;
                done_cyc = t;
            end
            if (done_cyc >= 0 && t > done_cyc && busy === 1'b1) post_busy++;
            if (abort_at >= 0 && out_valid === 1'b1 && beat == abort_at) begin
                rst = 1'b1;
                return;
            end
            start = 1'b0;
            if (poke_at >= 0 && ((out_valid === 1'b1 && beat == poke_at) || done === 1'b1))
                start = 1'b1;
            if (out_valid === 1'b1 && beat == stall_at && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (stall_at == 0 && beat == 0 && out_valid === 1'b1 && !out_ready && rf_addr !== '0)
                stall0_bad++;
            if (out_valid === 1'b1 && out_ready) begin
                cap_data.push_back(out_data);
                cap_idx.push_back(out_idx);
                cap_last.push_back(out_last);
                cap_cyc.push_back(t);
                beat++;
            end else if (out_valid === 1'b1) begin
                nstall++;
            end
            prev_hold = (out_valid === 1'b1) && !out_ready;
            pd = out_data; pi = out_idx; pl = out_last;
            if (done_cyc >= 0 && t >= done_cyc + 3) return;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [N+A+6-1:0] got;
        repeat (3) @(negedge clk);
        got = {rf_addr, halt_req, busy, done, out_valid, out_data, out_idx, out_last};
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rf_addr=%0h halt=%b busy=%b done=%b valid=%b data=%h idx=%0d last=%b, required all zero",
                     rf_addr, halt_req, busy, done, out_valid, out_data, out_idx, out_last);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy=%b valid=%b, required 0/0", busy, out_valid);
        end
        $display("reset: checked outputs after reset");
    endtask

    task automatic test_full_dump();
        load_spec();
        build_model();
        run_dump(-1, 0, 1'b0, -1, -1);
        n_cmp++;
        if (cap_data.size() != NBEATS) begin
            n_bad++;
            $display("FAIL full_beat_count: got %0d, required %0d", cap_data.size(), NBEATS);
        end
        for (int i = 0; i < NBEATS && i < cap_data.size(); i++) begin
            $display("beat %0d: cyc=%0d data=%h idx=%0d last=%b", i, cap_cyc[i], cap_data[i], cap_idx[i], cap_last[i]);
            n_cmp++;
            if (cap_data[i] !== exp_data[i] || cap_idx[i] !== exp_idx[i] || cap_last[i] !== exp_last[i]
                || cap_cyc[i] != ((i < NREGS) ? 2 + 2 * i : 2 * NREGS + 1)) begin
                n_bad++;
                $display("FAIL full_beat_%0d: got data=%h idx=%0d last=%b cyc=%0d, required data=%h idx=%0d last=%b cyc=%0d",
                         i, cap_data[i], cap_idx[i], cap_last[i], cap_cyc[i], exp_data[i], exp_idx[i], exp_last[i],
                         (i < NREGS) ? 2 + 2 * i : 2 * NREGS + 1);
            end
        end
        n_cmp++;
        if (ndone != 1 || done_cyc != T_DONE) begin
            n_bad++;
            $display("FAIL full_done: got %0d pulses at cyc %0d, required 1 at %0d", ndone, done_cyc, T_DONE);
        end
        n_cmp++;
        if (halt_first != 1 || halt_last != T_DONE - 1 || hb_bad != 0) begin
            n_bad++;
            $display("FAIL full_halt: got cyc %0d..%0d (halt!=busy %0d), required 1..%0d", halt_first, halt_last, hb_bad, T_DONE - 1);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        load_spec();
        build_model();
        run_dump(3, 5, 1'b0, -1, -1);
        bad = 0;
        for (int i = 0; i < NBEATS; i++)
            if (i >= cap_data.size() || cap_data[i] !== exp_data[i] || cap_idx[i] !== exp_idx[i] || cap_last[i] !== exp_last[i])
                bad++;
        n_cmp++;
        if (bad != 0 || cap_data.size() != NBEATS) begin
            n_bad++;
            $display("FAIL backpressure_beats: got %0d beats with %0d wrong, required %0d correct", cap_data.size(), bad, NBEATS);
        end
        n_cmp++;
        if (hold_bad != 0 || nstall != 5) begin
            n_bad++;
            $display("FAIL backpressure_hold: got %0d hold violations over %0d stalls, required 0 over 5", hold_bad, nstall);
        end
        n_cmp++;
        if (ndone != 1 || done_cyc != T_DONE + 5) begin
            n_bad++;
            $display("FAIL backpressure_done: got %0d pulses at cyc %0d, required 1 at %0d", ndone, done_cyc, T_DONE + 5);
        end
        $display("backpressure: %0d beats, done at cyc %0d", cap_data.size(), done_cyc);
    endtask

    task automatic test_start_ignored();
        int bad;
        load_spec();
        build_model();
        run_dump(-1, 0, 1'b0, 10, -1);
        bad = 0;
        for (int i = 0; i < NBEATS; i++)
            if (i >= cap_data.size() || cap_data[i] !== exp_data[i] || cap_idx[i] !== exp_idx[i] || cap_last[i] !== exp_last[i])
                bad++;
        n_cmp++;
        if (bad != 0 || cap_data.size() != NBEATS) begin
            n_bad++;
            $display("FAIL start_ignored_beats: got %0d beats with %0d wrong, required %0d correct", cap_data.size(), bad, NBEATS);
        end
        n_cmp++;
        if (ndone != 1 || done_cyc != T_DONE || post_busy != 0) begin
            n_bad++;
            $display("FAIL start_ignored_done: got %0d pulses at cyc %0d, busy after done %0d, required 1 at %0d, 0",
                     ndone, done_cyc, post_busy, T_DONE);
        end
        $display("start_ignored: %0d beats, %0d done pulse(s)", cap_data.size(), ndone);
    endtask

    task automatic test_reset_mid();
        int bad;
        load_random();
        build_model();
        run_dump(-1, 0, 1'b0, -1, 10);
        @(negedge clk);
        n_cmp++;
        if (ndone != 0 || cap_data.size() != 10) begin
            n_bad++;
            $display("FAIL reset_mid_abort: got %0d done, %0d beats, required 0 done, 10 beats", ndone, cap_data.size());
        end
        n_cmp++;
        if ({rf_addr, halt_req, busy, done, out_valid, out_data, out_idx, out_last} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got busy=%b valid=%b data=%h idx=%0d last=%b addr=%0d, required all zero",
                     busy, out_valid, out_data, out_idx, out_last, rf_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        run_dump(-1, 0, 1'b0, -1, -1);
        n_cmp++;
        if (cap_data.size() == 0 || cap_cyc[0] != 2 || cap_data[0] !== regs[0] || cap_idx[0] !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_restart: got first beat cyc=%0d data=%h, required cyc=2 data=%h idx=0",
                     (cap_cyc.size() > 0) ? cap_cyc[0] : -1, (cap_data.size() > 0) ? cap_data[0] : '0, regs[0]);
        end
        bad = 0;
        for (int i = 0; i < NBEATS; i++)
            if (i >= cap_data.size() || cap_data[i] !== exp_data[i] || cap_idx[i] !== exp_idx[i] || cap_last[i] !== exp_last[i])
                bad++;
        n_cmp++;
        if (bad != 0 || ndone != 1) begin
            n_bad++;
            $display("FAIL reset_mid_redump: got %0d wrong beats, %0d done, required 0 and 1", bad, ndone);
        end
        $display("reset_mid: restart dump of %0d beats", cap_data.size());
    endtask

    task automatic test_stall_beat0();
        int bad;
        load_random();
        build_model();
        run_dump(0, 20, 1'b0, -1, -1);
        n_cmp++;
        if (stall0_bad != 0 || hold_bad != 0 || nstall != 20) begin
            n_bad++;
            $display("FAIL stall_beat0_hold: got addr errors %0d, hold violations %0d, stalls %0d, required 0/0/20",
                     stall0_bad, hold_bad, nstall);
        end
        bad = 0;
        for (int i = 0; i < NBEATS; i++)
            if (i >= cap_data.size() || cap_data[i] !== exp_data[i] || cap_idx[i] !== exp_idx[i] || cap_last[i] !== exp_last[i])
                bad++;
        n_cmp++;
        if (bad != 0 || cap_data.size() != NBEATS || done_cyc != T_DONE + 20) begin
            n_bad++;
            $display("FAIL stall_beat0_stream: got %0d beats (%0d wrong), done cyc %0d, required %0d beats, done cyc %0d",
                     cap_data.size(), bad, done_cyc, NBEATS, T_DONE + 20);
        end
        $display("stall_beat0: %0d beats, done at cyc %0d", cap_data.size(), done_cyc);
    endtask

    task automatic test_random();
        int bad;
        for (int r = 0; r < 3; r++) begin
            load_random();
            build_model();
            run_dump(-1, 0, 1'b1, -1, -1);
            bad = 0;
            for (int i = 0; i < NBEATS; i++)
                if (i >= cap_data.size() || cap_data[i] !== exp_data[i] || cap_idx[i] !== exp_idx[i] || cap_last[i] !== exp_last[i])
                    bad++;
            n_cmp++;
            if (bad != 0 || cap_data.size() != NBEATS || hold_bad != 0) begin
                n_bad++;
                $display("FAIL random_%0d_stream: got %0d beats (%0d wrong, %0d hold violations), required %0d correct",
                         r, cap_data.size(), bad, hold_bad, NBEATS);
            end
            n_cmp++;
            if (ndone != 1 || done_cyc != T_DONE + nstall || halt_last != done_cyc - 1 || hb_bad != 0) begin
                n_bad++;
                $display("FAIL random_%0d_timing: got done %0d at cyc %0d, halt end %0d, required 1 at %0d, halt end %0d",
                         r, ndone, done_cyc, halt_last, T_DONE + nstall, T_DONE + nstall - 1);
            end
            $display("random %0d: %0d beats, %0d stalls, done at cyc %0d", r, cap_data.size(), nstall, done_cyc);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < NREGS; k++) regs[k] = '0;
        test_reset();
        test_full_dump();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_stall_beat0();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine for the core's integer register file. On a single-cycle `start` pulse it walks registers x0..x(NREGS-1) through one dedicated combinational read port and streams each value out over a valid/ready handshake. It also requests a core halt while scanning so the snapshot is consistent. It sits between the register file's debug read port and the debug/trace transport.

## Interface
Parameters:
- `N`, 32, data width of one register and of `out_data`.
- `NREGS`, 32, number of registers scanned.
- `A`, `$clog2(NREGS)`, register index width.

Ports:
- `clk`, in, 1, clock; all state changes on its rising edge.
- `rst`, in, 1, reset: asynchronous, active-high.
- `start`, in, 1, dump request; sampled only in IDLE.
- `rf_addr`, out, A, register index driven to the register-file read port.
- `rf_data`, in, N, combinational read data for `rf_addr`, valid in the same cycle.
- `halt_req`, out, 1, core halt request; equals `busy`.
- `busy`, out, 1, high in READ, SEND and CSUM.
- `done`, out, 1, one-cycle pulse after the final beat is accepted.
- `out_valid`, out, 1, stream beat valid.
- `out_ready`, in, 1, downstream accept.
- `out_data`, out, N, beat payload (registered).
- `out_idx`, out, A, register index of the current beat.
- `out_last`, out, 1, marks the final beat of a dump.

## Operation
- FSM states: IDLE, READ, SEND, CSUM (only when configured), DONE.
- IDLE:
  - `rf_addr`=0, `out_valid`=0.
  - `start`=1 → clear index counter `idx` to 0 and the checksum accumulator to 0 → READ.
- READ:
  - `rf_addr`=`idx`.
  - Capture `rf_data` into `out_data`; `out_idx`←`idx`.
  - Checksum accumulator ^= `rf_data` → SEND.
- SEND:
  - `out_valid`=1.
  - `out_last`=1 iff `idx`==NREGS-1 and checksum is not compiled in.
  - On `out_valid && out_ready`:
    - if `idx`==NREGS-1 → CSUM when configured, otherwise DONE;
    - else `idx`++ (A-bit, no wrap reachable) → READ.
- CSUM:
  - `out_valid`=1, `out_data`=accumulator, `out_idx`=0, `out_last`=1.
  - On handshake → DONE.
- DONE: `done`=1 for exactly one cycle → IDLE unconditionally. `start` in DONE is ignored.
- `start` outside IDLE is ignored; it is not queued.
- Beat hold rule: while `out_valid && !out_ready`, `out_data`, `out_idx` and `out_last` are held stable. `out_valid` never drops without a handshake.
- x0 is read through the port like any other register, with no special-casing.
- Reset mid-dump: immediate return to IDLE, the dump is abandoned, and no `done` is issued. The next `start` restarts at index 0.

## Timing
- Reset values: `rf_addr`=0, `halt_req`=0, `busy`=0, `done`=0, `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `idx`=0, accumulator=0.
- `start` sampled at edge E: READ during cycle E+1, first `out_valid` in cycle E+2.
- Throughput: one beat per 2 cycles with `out_ready` held high. Each stall cycle adds one cycle.
- Full dump, ready always high, checksum off: beat i valid in cycle E+2+2i, last beat (i=31) in E+64, `done` in E+65.
- With checksum: checksum beat in E+65, `done` in E+66.
- `halt_req`/`busy` rise in E+1 and fall when DONE is entered.
- `done` is a registered-state decode: high only in the DONE cycle.

## Configuration
- `REGFILE_DUMP_CHECKSUM_EN` defined:
  - CSUM state compiled in.
  - One extra beat after register NREGS-1 carries the XOR of all NREGS values, with `out_idx`=0 and `out_last`=1.
  - Register NREGS-1's beat has `out_last`=0.
- Undefined: no accumulator and no CSUM state; register NREGS-1's beat carries `out_last`=1.

## Test plan
- Preload x0=0, xk=0x100+k (k=1..31); pulse `start`, `out_ready`=1, checksum off → 32 beats in index order with data 0..0x11F; beat 31 in cycle E+64 with `out_last`=1; `done` in E+65; `halt_req` high in E+1..E+64.
- Same preload, `REGFILE_DUMP_CHECKSUM_EN` defined → beat 31 has `out_last`=0; extra beat with data 0x00000100, `out_idx`=0, `out_last`=1 in E+65; `done` in E+66.
- Backpressure: drop `out_ready` for 5 cycles while beat 3 is valid → `out_data` held at 0x103 and `out_idx` held at 3 for all 5 cycles; stream resumes at beat 4; `done` is 5 cycles later than the unstalled run.
- `start` pulsed again during beat 10 and again in the DONE cycle → no effect; exactly 32 beats and one `done` pulse.
- Assert `rst` during beat 10 → next cycle all outputs 0 and `busy`=0, no `done`; a fresh `start` yields beat 0 with data 0 at E'+2.
- `start` with `out_ready`=0 for 20 cycles at beat 0 → `out_valid` stays 1, `rf_addr` stays 0, no beat lost.
